// File: rtl/spell_commit.sv
// spell_commit: commit/writeback stage of the Spell stack CPU.
// Retires one decoded bundle from execute per accepted transaction:
// stack-file writes, sp/pc update, an optional memory write handshake,
// an optional delay countdown and an optional sleep until woken.
// Owns the 32x8 stack file and feeds the two top entries back to execute.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   commit_valid / commit_ready  bundle handshake (ready only in IDLE)
//   exec_next_pc, exec_next_sp   pc/sp after the instruction
//   stack_write_count            0/1/2 entries to write (3 behaves as 0)
//   set_stack_top/belowtop       data for the new top / below-top entries
//   memory_write_type/addr/data  memory write request (type 0 = none)
//   delay_amount                 delay units (0 = none), scaled by DELAY_SCALE
//   sleep, wake                  enter sleep after commit / leave sleep
//   pc, sp                       committed architectural state
//   stack_top, stack_belowtop    stack[sp-1], stack[sp-2], combinational
//   mem_req/ack, mem_type/addr/wdata  memory write bus, held while mem_req=1
//   commit_done                  one-cycle pulse when a bundle fully retires
//   sleeping                     high while in SLEEP
module spell_commit #(
  parameter int DELAY_SCALE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       commit_valid,
  output logic       commit_ready,
  input  logic [7:0] exec_next_pc,
  input  logic [4:0] exec_next_sp,
  input  logic [1:0] stack_write_count,
  input  logic [7:0] set_stack_top,
  input  logic [7:0] set_stack_belowtop,
  input  logic [1:0] memory_write_type,
  input  logic [7:0] memory_write_addr,
  input  logic [7:0] memory_write_data,
  input  logic [7:0] delay_amount,
  input  logic       sleep,
  input  logic       wake,
  output logic [7:0] pc,
  output logic [4:0] sp,
  output logic [7:0] stack_top,
  output logic [7:0] stack_belowtop,
  output logic       mem_req,
  input  logic       mem_ack,
  output logic [1:0] mem_type,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       commit_done,
  output logic       sleeping
);

  localparam logic [1:0] MEM_NONE = 2'd0;

  typedef enum logic [1:0] {IDLE, MEMWR, DELAY, SLEEP} state_t;

  state_t      state;
  logic [15:0] delay_count;
  logic [7:0]  stack [0:31];

  logic        accept;
  logic [4:0]  top_idx;
  logic [4:0]  below_idx;
  logic [15:0] delay_load;

  assign accept    = commit_valid && (state == IDLE);
  // 5-bit arithmetic gives the modulo-32 wrap for free.
  assign top_idx   = exec_next_sp - 5'd1;
  assign below_idx = exec_next_sp - 5'd2;
  // Counter is loaded with N-1 so that ready stays low for exactly N cycles.
  assign delay_load = 16'(32'(delay_amount) * 32'(DELAY_SCALE) - 32'd1);

  assign commit_ready   = (state == IDLE);
  assign sleeping       = (state == SLEEP);
  assign stack_top      = stack[sp - 5'd1];
  assign stack_belowtop = stack[sp - 5'd2];

  // Stack file is deliberately not reset; writes are suppressed during reset.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      if (stack_write_count == 2'd1 || stack_write_count == 2'd2)
        stack[top_idx] <= set_stack_top;
      if (stack_write_count == 2'd2)
        stack[below_idx] <= set_stack_belowtop;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= 8'd0;
      sp          <= 5'd0;
      mem_req     <= 1'b0;
      mem_type    <= MEM_NONE;
      mem_addr    <= 8'd0;
      mem_wdata   <= 8'd0;
      commit_done <= 1'b0;
      delay_count <= 16'd0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        IDLE: begin
          if (commit_valid) begin
            pc <= exec_next_pc;
            sp <= exec_next_sp;
            // Memory write outranks delay, which outranks sleep.
            if (memory_write_type != MEM_NONE) begin
              state     <= MEMWR;
              mem_req   <= 1'b1;
              mem_type  <= memory_write_type;
              mem_addr  <= memory_write_addr;
              mem_wdata <= memory_write_data;
            end else if (delay_amount != 8'd0) begin
              state       <= DELAY;
              delay_count <= delay_load;
            end else if (sleep) begin
              state <= SLEEP;
            end else begin
              commit_done <= 1'b1;
            end
          end
        end
        MEMWR: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            state       <= IDLE;
            commit_done <= 1'b1;
          end
        end
        DELAY: begin
          if (delay_count == 16'd0) begin
            state       <= IDLE;
            commit_done <= 1'b1;
          end else begin
            delay_count <= delay_count - 16'd1;
          end
        end
        SLEEP: begin
          if (wake) begin
            state       <= IDLE;
            commit_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spell_commit.sv
// tb_spell_commit: self-checking bench for spell_commit.
// Directed scenarios plus randomized bundles checked against a behavioural
// model (stack array, sp, pc, expected busy duration per bundle kind).
module tb_spell_commit;

  localparam int SCALE = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       commit_valid;
  logic       commit_ready;
  logic [7:0] exec_next_pc;
  logic [4:0] exec_next_sp;
  logic [1:0] stack_write_count;
  logic [7:0] set_stack_top;
  logic [7:0] set_stack_belowtop;
  logic [1:0] memory_write_type;
  logic [7:0] memory_write_addr;
  logic [7:0] memory_write_data;
  logic [7:0] delay_amount;
  logic       sleep;
  logic       wake;
  logic [7:0] pc;
  logic [4:0] sp;
  logic [7:0] stack_top;
  logic [7:0] stack_belowtop;
  logic       mem_req;
  logic       mem_ack;
  logic [1:0] mem_type;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       commit_done;
  logic       sleeping;

  spell_commit #(.DELAY_SCALE(SCALE)) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .exec_next_pc(exec_next_pc), .exec_next_sp(exec_next_sp),
    .stack_write_count(stack_write_count),
    .set_stack_top(set_stack_top), .set_stack_belowtop(set_stack_belowtop),
    .memory_write_type(memory_write_type), .memory_write_addr(memory_write_addr),
    .memory_write_data(memory_write_data), .delay_amount(delay_amount),
    .sleep(sleep), .wake(wake), .pc(pc), .sp(sp),
    .stack_top(stack_top), .stack_belowtop(stack_belowtop),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_type(mem_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .commit_done(commit_done), .sleeping(sleeping)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [7:0] m_stack [32];
  bit         m_known [32];
  logic [7:0] m_pc;
  logic [4:0] m_sp;

  // Observations gathered while a bundle is busy.
  int obs_low, obs_req, obs_sleep;
  bit obs_done, obs_fields_bad, obs_timeout;

  task automatic clear_inputs();
    commit_valid = 0; exec_next_pc = 0; exec_next_sp = 0; stack_write_count = 0;
    set_stack_top = 0; set_stack_belowtop = 0; memory_write_type = 0;
    memory_write_addr = 0; memory_write_data = 0; delay_amount = 0;
    sleep = 0; wake = 0; mem_ack = 0;
  endtask

  task automatic model_commit(input logic [7:0] npc, input logic [4:0] nsp,
                              input logic [1:0] cnt, input logic [7:0] top, below);
    m_pc = npc;
    m_sp = nsp;
    if (cnt == 2'd1 || cnt == 2'd2) begin
      m_stack[5'(nsp - 5'd1)] = top;
      m_known[5'(nsp - 5'd1)] = 1'b1;
    end
    if (cnt == 2'd2) begin
      m_stack[5'(nsp - 5'd2)] = below;
      m_known[5'(nsp - 5'd2)] = 1'b1;
    end
  endtask

  // Cycles commit_ready should stay low for a bundle, from the priority rules.
  function automatic int exp_low(input logic [1:0] mt, input logic [7:0] dl,
                                 input logic slp, input int ack_at, input int wake_at);
    if (mt != 2'd0) return ack_at;
    if (dl != 8'd0) return int'(dl) * SCALE;
    if (slp) return wake_at;
    return 0;
  endfunction

  // Runs from the negedge after the commit edge until ready returns, driving
  // ack/wake on the given busy cycle and optional ignorable noise.
  task automatic watch(input int ack_at, input int wake_at, input bit noise,
                       input logic [1:0] et, input logic [7:0] ea, ed);
    obs_low = 0; obs_req = 0; obs_sleep = 0;
    obs_done = 0; obs_fields_bad = 0; obs_timeout = 1;
    for (int i = 0; i < 1000; i++) begin
      if (commit_ready) begin
        obs_done = commit_done;
        obs_timeout = 0;
        break;
      end
      obs_low++;
      if (mem_req) begin
        obs_req++;
        if (mem_type !== et || mem_addr !== ea || mem_wdata !== ed) obs_fields_bad = 1;
      end
      if (sleeping) obs_sleep++;
      if (obs_low == ack_at) mem_ack = 1;
      if (obs_low == wake_at) wake = 1;
      if (noise && $urandom_range(0, 2) == 0) begin
        commit_valid = 1;
        exec_next_pc = 8'($urandom);
        exec_next_sp = 5'($urandom);
        stack_write_count = 2'($urandom);
        set_stack_top = 8'($urandom);
        memory_write_type = 2'($urandom);
        delay_amount = 8'($urandom);
        if (ack_at == 0) mem_ack = 1;
        if (wake_at == 0) wake = 1;
      end
      @(negedge clock);
      commit_valid = 0; mem_ack = 0; wake = 0;
    end
  endtask

  task automatic run_txn(input logic [7:0] npc, input logic [4:0] nsp,
                         input logic [1:0] cnt, input logic [7:0] top, below,
                         input logic [1:0] mt, input logic [7:0] ma, md, dl,
                         input logic slp, input int ack_at, wake_at, input bit noise);
    commit_valid = 1; exec_next_pc = npc; exec_next_sp = nsp;
    stack_write_count = cnt; set_stack_top = top; set_stack_belowtop = below;
    memory_write_type = mt; memory_write_addr = ma; memory_write_data = md;
    delay_amount = dl; sleep = slp;
    @(negedge clock);
    clear_inputs();
    model_commit(npc, nsp, cnt, top, below);
    watch(ack_at, wake_at, noise, mt, ma, md);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    repeat (3) @(negedge clock);
    tests++;
    if (pc !== 8'd0 || sp !== 5'd0) begin
      fails++; $display("FAIL reset_pc_sp: pc=%h sp=%h, required 0/0", pc, sp);
    end
    tests++;
    if (commit_ready !== 1'b1 || mem_req !== 1'b0 || commit_done !== 1'b0 || sleeping !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: ready=%b req=%b done=%b sleeping=%b, required 1/0/0/0",
                        commit_ready, mem_req, commit_done, sleeping);
    end
    tests++;
    if (mem_type !== 2'd0 || mem_addr !== 8'd0 || mem_wdata !== 8'd0) begin
      fails++; $display("FAIL reset_bus: type=%h addr=%h wdata=%h, required 0", mem_type, mem_addr, mem_wdata);
    end
    reset = 0;
    m_pc = 0; m_sp = 0;
    foreach (m_known[i]) m_known[i] = 0;
    @(negedge clock);
    $display("[TB] reset checked");
  endtask

  task automatic test_push();
    run_txn(8'd1, 5'd1, 2'd1, 8'h41, 8'h00, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0, 0);
    tests++;
    if (obs_low != 0 || obs_done !== 1'b1) begin
      fails++; $display("FAIL push_done: low=%0d done=%b, required 0/1", obs_low, obs_done);
    end
    tests++;
    if (sp !== 5'd1 || stack_top !== 8'h41 || pc !== 8'd1) begin
      fails++; $display("FAIL push_state: sp=%0d top=%h pc=%h, required 1/41/01", sp, stack_top, pc);
    end
    $display("[TB] push: sp=%0d top=%h", sp, stack_top);
  endtask

  task automatic test_add();
    run_txn(8'd2, 5'd2, 2'd2, 8'd4, 8'd3, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0, 0);
    run_txn(8'd3, 5'd1, 2'd1, 8'h07, 8'h00, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0, 0);
    tests++;
    if (sp !== 5'd1 || stack_top !== 8'h07) begin
      fails++; $display("FAIL add: sp=%0d top=%h, required 1/07", sp, stack_top);
    end
    $display("[TB] add: sp=%0d top=%h", sp, stack_top);
  endtask

  task automatic test_swap();
    run_txn(8'd4, 5'd2, 2'd2, 8'd4, 8'd3, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0, 0);
    run_txn(8'd5, 5'd2, 2'd2, 8'd3, 8'd4, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0, 0);
    tests++;
    if (sp !== 5'd2 || stack_top !== 8'd3 || stack_belowtop !== 8'd4) begin
      fails++; $display("FAIL swap: sp=%0d top=%h below=%h, required 2/03/04", sp, stack_top, stack_belowtop);
    end
    $display("[TB] swap: top=%h below=%h", stack_top, stack_belowtop);
  endtask

  task automatic test_memwrite();
    run_txn(8'd6, 5'd2, 2'd0, 8'd0, 8'd0, 2'd1, 8'h10, 8'h55, 8'd0, 1'b0, 4, 0, 0);
    tests++;
    if (obs_timeout || obs_low != 4 || obs_req != 4) begin
      fails++; $display("FAIL memwr_hold: timeout=%b low=%0d req=%0d, required 0/4/4", obs_timeout, obs_low, obs_req);
    end
    tests++;
    if (obs_fields_bad || obs_done !== 1'b1 || mem_req !== 1'b0) begin
      fails++; $display("FAIL memwr_end: fields_bad=%b done=%b req=%b, required 0/1/0", obs_fields_bad, obs_done, mem_req);
    end
    $display("[TB] memwrite: req held %0d cycles", obs_req);
  endtask

  task automatic test_delay();
    run_txn(8'd7, 5'd2, 2'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 8'd5, 1'b0, 0, 0, 0);
    tests++;
    if (obs_timeout || obs_low != 5 * SCALE || obs_done !== 1'b1) begin
      fails++; $display("FAIL delay: timeout=%b low=%0d done=%b, required 0/%0d/1", obs_timeout, obs_low, obs_done, 5 * SCALE);
    end
    @(negedge clock);
    tests++;
    if (commit_done !== 1'b0) begin
      fails++; $display("FAIL done_pulse: done=%b a cycle later, required 0", commit_done);
    end
    $display("[TB] delay: ready low %0d cycles", obs_low);
  endtask

  task automatic test_sleep();
    run_txn(8'd8, 5'd2, 2'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b1, 0, 10, 0);
    tests++;
    if (obs_timeout || obs_low != 10 || obs_sleep != 10 || obs_done !== 1'b1 || sleeping !== 1'b0) begin
      fails++; $display("FAIL sleep: timeout=%b low=%0d sleeping_cycles=%0d done=%b, required 0/10/10/1",
                        obs_timeout, obs_low, obs_sleep, obs_done);
    end
    $display("[TB] sleep: woke after %0d cycles", obs_low);
  endtask

  task automatic test_reset_memwr();
    commit_valid = 1; exec_next_pc = 8'h33; exec_next_sp = 5'd3;
    memory_write_type = 2'd2; memory_write_addr = 8'h20; memory_write_data = 8'hAA;
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    tests++;
    if (mem_req !== 1'b1 || commit_ready !== 1'b0) begin
      fails++; $display("FAIL memwr_pending: req=%b ready=%b, required 1/0", mem_req, commit_ready);
    end
    reset = 1;
    @(negedge clock);
    tests++;
    if (mem_req !== 1'b0 || sp !== 5'd0 || pc !== 8'd0 || commit_ready !== 1'b1) begin
      fails++; $display("FAIL reset_memwr: req=%b sp=%0d pc=%h ready=%b, required 0/0/00/1",
                        mem_req, sp, pc, commit_ready);
    end
    reset = 0;
    m_sp = 0; m_pc = 0;
    @(negedge clock);
    $display("[TB] reset during memwrite: req=%b sp=%0d", mem_req, sp);
  endtask

  task automatic test_wrap();
    run_txn(8'd9, 5'd31, 2'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0, 0);
    run_txn(8'd10, 5'd0, 2'd1, 8'h99, 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0, 0);
    tests++;
    if (sp !== 5'd0 || stack_top !== 8'h99) begin
      fails++; $display("FAIL wrap: sp=%0d top=%h, required 0/99", sp, stack_top);
    end
    $display("[TB] wrap: sp=%0d top=%h", sp, stack_top);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] npc, top, below, ma, md, dl;
      logic [4:0] nsp;
      logic [1:0] cnt, mt;
      logic       slp;
      int         kind, ack_at, wake_at, want;
      npc = 8'($urandom);
      nsp = 5'(m_sp + 5'($urandom_range(0, 2)) - 5'd1);
      cnt = 2'($urandom);
      top = 8'($urandom); below = 8'($urandom);
      ma = 8'($urandom); md = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      mt = 2'd0; dl = 8'd0; slp = 1'b0; ack_at = 0; wake_at = 0;
      if (kind == 1) begin
        mt = 2'($urandom_range(1, 3)); ack_at = int'($urandom_range(1, 6));
        dl = 8'($urandom_range(0, 3)); slp = 1'($urandom);
      end else if (kind == 2) begin
        dl = 8'($urandom_range(1, 12)); slp = 1'($urandom);
        if (slp) wake_at = 1;
      end else if (kind == 3) begin
        slp = 1'b1; wake_at = int'($urandom_range(1, 8));
      end
      want = exp_low(mt, dl, slp, ack_at, wake_at);
      run_txn(npc, nsp, cnt, top, below, mt, ma, md, dl, slp, ack_at, wake_at, 1);
      tests++;
      if (obs_timeout || obs_low != want || obs_done !== 1'b1) begin
        fails++; $display("FAIL rand_busy[%0d]: timeout=%b low=%0d done=%b, required 0/%0d/1",
                          n, obs_timeout, obs_low, obs_done, want);
      end
      tests++;
      if (obs_req != ((mt != 2'd0) ? ack_at : 0) || obs_fields_bad) begin
        fails++; $display("FAIL rand_mem[%0d]: req_cycles=%0d fields_bad=%b, required %0d/0",
                          n, obs_req, obs_fields_bad, (mt != 2'd0) ? ack_at : 0);
      end
      tests++;
      if (sp !== m_sp || pc !== m_pc) begin
        fails++; $display("FAIL rand_sp_pc[%0d]: sp=%0d pc=%h, required %0d/%h", n, sp, pc, m_sp, m_pc);
      end
      if (m_known[5'(m_sp - 5'd1)]) begin
        tests++;
        if (stack_top !== m_stack[5'(m_sp - 5'd1)]) begin
          fails++; $display("FAIL rand_top[%0d]: top=%h, required %h", n, stack_top, m_stack[5'(m_sp - 5'd1)]);
        end
      end
      if (m_known[5'(m_sp - 5'd2)]) begin
        tests++;
        if (stack_belowtop !== m_stack[5'(m_sp - 5'd2)]) begin
          fails++; $display("FAIL rand_below[%0d]: below=%h, required %h", n, stack_belowtop, m_stack[5'(m_sp - 5'd2)]);
        end
      end
      $display("[TB] rand %0d: kind=%0d cnt=%0d sp=%0d low=%0d", n, kind, cnt, sp, obs_low);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_push();
    test_add();
    test_swap();
    test_memwrite();
    test_delay();
    test_sleep();
    test_reset_memwr();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
